d8_registres: RTL and testbench

Register file at the receiving end of the opcode write-enable decode: accepts the write strobe, register index and data from the writeback path, commits writes through a one-deep pending stage, and serves two registered read ports for the operand fetch stage. Read ports forward from both the incoming write and the pending write, so back-to-back dependent instructions see the newest value without stalls.

---
 rtl/d8_pkg.sv | 11 +
 rtl/d8_reg_read_port.sv | 36 +++
 rtl/d8_registres.sv | 81 ++++++++
 tb/tb_d8_registres.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/d8_pkg.sv
// Shared constants and types for the d8 register file.
// Pure declarations; no logic, latency or flow control of its own.
package d8_pkg;
  localparam int D8_NREG = 8;
  localparam int D8_DW   = 8;
  localparam int D8_AW   = $clog2(D8_NREG);

  typedef logic [D8_AW-1:0] reg_idx_t;

  localparam logic [D8_DW-1:0] D8_RST_DAT = '0;
endpackage

// File: rtl/d8_reg_read_port.sv
// One read port: newest-source forward mux (incoming write > pending > array) into an output register.
// Latency 1 cycle; never stalls, holds its value while rd_en is low.
import d8_pkg::*;

module d8_reg_read_port #(
  parameter int DW = D8_DW,
  parameter int AW = D8_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_sel,
  input  logic          wr_w,
  input  logic [AW-1:0] wr_sel,
  input  logic [DW-1:0] wr_dat,
  input  logic          pend_v,
  input  logic [AW-1:0] pend_sel,
  input  logic [DW-1:0] pend_dat,
  input  logic [DW-1:0] arr_dat,
  output logic [DW-1:0] rd_dat
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_dat <= DW'(D8_RST_DAT);
    end else if (rd_en) begin
      if (wr_w && (wr_sel == rd_sel))
        rd_dat <= wr_dat;
      else if (pend_v && (pend_sel == rd_sel))
        rd_dat <= pend_dat;
      else
        rd_dat <= arr_dat;
    end
  end

endmodule

// File: rtl/d8_registres.sv
// Register file with one-deep pending write stage and two forwarding read ports (D8_REG_ZERO_EN: r0 reads 0).
// Write-to-array 2 edges, read latency 1 cycle; never back-pressures.
import d8_pkg::*;

module d8_registres #(
  parameter  int NREG = D8_NREG,
  parameter  int DW   = D8_DW,
  localparam int AW   = $clog2(NREG)
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  input  logic          wr_w,
  input  logic [AW-1:0] wr_sel,
  input  logic [DW-1:0] wr_dat,
  input  logic          rd_en_a,
  input  logic [AW-1:0] rd_sel_a,
  input  logic          rd_en_b,
  input  logic [AW-1:0] rd_sel_b,
  output logic [DW-1:0] rd_dat_a,
  output logic [DW-1:0] rd_dat_b,
  output logic          pend_v,
  output logic [AW-1:0] pend_sel
);

  logic [DW-1:0] mem [NREG];
  logic [DW-1:0] pend_dat;
  logic          wr_take;

  // Dropping r0 writes at capture keeps r0 out of the array, the pending
  // stage and the forward path, so every read of r0 naturally returns 0.
`ifdef D8_REG_ZERO_EN
  assign wr_take = wr_w && (wr_sel != '0);
`else
  assign wr_take = wr_w;
`endif

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < NREG; i++) mem[i] <= DW'(D8_RST_DAT);
      pend_v   <= 1'b0;
      pend_sel <= '0;
      pend_dat <= DW'(D8_RST_DAT);
    end else begin
      if (pend_v) mem[pend_sel] <= pend_dat;
      pend_v   <= wr_take;
      pend_sel <= wr_take ? wr_sel : '0;
      pend_dat <= wr_take ? wr_dat : DW'(D8_RST_DAT);
    end
  end

  d8_reg_read_port #(.DW(DW), .AW(AW)) u_port_a (
    .clk      (sys_clk),
    .rst_n    (sys_rst_n),
    .rd_en    (rd_en_a),
    .rd_sel   (rd_sel_a),
    .wr_w     (wr_take),
    .wr_sel   (wr_sel),
    .wr_dat   (wr_dat),
    .pend_v   (pend_v),
    .pend_sel (pend_sel),
    .pend_dat (pend_dat),
    .arr_dat  (mem[rd_sel_a]),
    .rd_dat   (rd_dat_a)
  );

  d8_reg_read_port #(.DW(DW), .AW(AW)) u_port_b (
    .clk      (sys_clk),
    .rst_n    (sys_rst_n),
    .rd_en    (rd_en_b),
    .rd_sel   (rd_sel_b),
    .wr_w     (wr_take),
    .wr_sel   (wr_sel),
    .wr_dat   (wr_dat),
    .pend_v   (pend_v),
    .pend_sel (pend_sel),
    .pend_dat (pend_dat),
    .arr_dat  (mem[rd_sel_b]),
    .rd_dat   (rd_dat_b)
  );

endmodule

// File: tb/tb_d8_registres.sv
// Bench for d8_registres: architectural-state reference model feeding a scoreboard queue, checked by a negedge monitor.
module tb_d8_registres;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic       wr_w;
  logic [2:0] wr_sel;
  logic [7:0] wr_dat;
  logic       rd_en_a, rd_en_b;
  logic [2:0] rd_sel_a, rd_sel_b;
  logic [7:0] rd_dat_a, rd_dat_b;
  logic       pend_v;
  logic [2:0] pend_sel;

  d8_registres dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .wr_w      (wr_w),
    .wr_sel    (wr_sel),
    .wr_dat    (wr_dat),
    .rd_en_a   (rd_en_a),
    .rd_sel_a  (rd_sel_a),
    .rd_en_b   (rd_en_b),
    .rd_sel_b  (rd_sel_b),
    .rd_dat_a  (rd_dat_a),
    .rd_dat_b  (rd_dat_b),
    .pend_v    (pend_v),
    .pend_sel  (pend_sel)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       pv;
    logic [2:0] ps;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

`ifdef D8_REG_ZERO_EN
  localparam bit ZERO_EN = 1'b1;
`else
  localparam bit ZERO_EN = 1'b0;
`endif

  // Reference model: the architectural register contents. A write is seen by
  // reads sampled at its own edge, so pipelining never appears here.
  logic [7:0] arch [8];
  logic [7:0] m_a, m_b;

  function automatic logic [7:0] newest(input logic [2:0] sel);
    if (ZERO_EN && sel == 3'd0) return 8'h00;
    if (wr_w && wr_sel == sel) return wr_dat;
    return arch[sel];
  endfunction

  task automatic model_edge();
    exp_t e;
    logic takes;
    if (!sys_rst_n) begin
      for (int i = 0; i < 8; i++) arch[i] = 8'h00;
      m_a = 8'h00;
      m_b = 8'h00;
      e = '{a: 8'h00, b: 8'h00, pv: 1'b0, ps: 3'd0};
    end else begin
      takes = wr_w && !(ZERO_EN && wr_sel == 3'd0);
      if (rd_en_a) m_a = newest(rd_sel_a);
      if (rd_en_b) m_b = newest(rd_sel_b);
      if (takes) arch[wr_sel] = wr_dat;
      e = '{a: m_a, b: m_b, pv: takes, ps: takes ? wr_sel : 3'd0};
    end
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge sys_clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("rd_dat_a", rd_dat_a, e.a);
      check("rd_dat_b", rd_dat_b, e.b);
      check("pend_v",   pend_v,   e.pv);
      check("pend_sel", pend_sel, e.ps);
    end
  end

  task automatic step(input logic rst, input logic w, input logic [2:0] ws,
                      input logic [7:0] wd, input logic ea, input logic [2:0] sa,
                      input logic eb, input logic [2:0] sb);
    sys_rst_n = rst;
    wr_w      = w;
    wr_sel    = ws;
    wr_dat    = wd;
    rd_en_a   = ea;
    rd_sel_a  = sa;
    rd_en_b   = eb;
    rd_sel_b  = sb;
    @(posedge sys_clk);
    model_edge();
    #1;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) arch[i] = 8'h00;
    m_a = 8'h00;
    m_b = 8'h00;

    // Reset, including a write in flight when reset arrives
    step(0, 0, 0, 8'h00, 0, 0, 0, 0);
    step(1, 1, 3, 8'h5A, 0, 0, 0, 0);
    step(0, 1, 3, 8'h5A, 1, 3, 1, 3);
    step(1, 0, 0, 8'h00, 1, 3, 1, 3);
    step(1, 0, 0, 8'h00, 0, 0, 0, 0);

    // Same-cycle forward
    step(1, 1, 2, 8'hA5, 1, 2, 0, 0);
    // Pending-stage forward
    step(1, 1, 5, 8'h11, 0, 0, 0, 0);
    step(1, 0, 0, 8'h00, 0, 0, 1, 5);
    // Back-to-back writes to one index
    step(1, 1, 7, 8'h01, 0, 0, 0, 0);
    step(1, 1, 7, 8'h02, 0, 0, 0, 0);
    step(1, 0, 0, 8'h00, 0, 0, 0, 0);
    step(1, 0, 0, 8'h00, 1, 7, 1, 7);
    // Hold while the selected register changes underneath
    step(1, 1, 4, 8'h33, 0, 0, 0, 0);
    step(1, 0, 0, 8'h00, 1, 4, 0, 0);
    step(1, 1, 4, 8'h44, 0, 4, 0, 0);
    step(1, 0, 0, 8'h00, 0, 4, 0, 0);
    step(1, 0, 0, 8'h00, 0, 4, 0, 0);
    step(1, 0, 0, 8'h00, 1, 4, 0, 0);
    // Register 0 write with same-cycle read
    step(1, 1, 0, 8'hFF, 1, 0, 0, 0);
    step(1, 0, 0, 8'h00, 1, 0, 1, 0);
    step(1, 0, 0, 8'h00, 0, 0, 0, 0);

    // Randomized traffic with narrow index focus to provoke forwarding hits
    for (int n = 0; n < 400; n++) begin
      logic [2:0] ws, sa, sb;
      ws = 3'($urandom_range(0, 7));
      sa = ($urandom_range(0, 2) == 0) ? ws : 3'($urandom_range(0, 7));
      sb = ($urandom_range(0, 2) == 0) ? sa : 3'($urandom_range(0, 7));
      step(($urandom_range(0, 59) != 0), ($urandom_range(0, 3) != 0), ws,
           8'($urandom), ($urandom_range(0, 3) != 0), sa,
           ($urandom_range(0, 3) != 0), sb);
    end

    step(1, 0, 0, 8'h00, 0, 0, 0, 0);
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge sys_clk);
    if (exp_q.size() > 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
